reg_writeback: RTL and testbench

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback.sv | 145 ++++++++++++++
 tb/tb_reg_writeback.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Writeback arbiter: merges ALU results and a queue of load results onto a single
// registered register-file write port, with load-starvation protection and hazard query.
module reg_writeback #(
    parameter int REG_BIT_WIDTH    = 32,
    parameter int NUM_OF_REGS      = 32,
    parameter int REG_ENCODE_WIDTH = $clog2(NUM_OF_REGS),
    parameter int LQ_DEPTH         = 4,
    parameter int STARVE_LIMIT     = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    input  logic [REG_ENCODE_WIDTH-1:0] alu_rd_addr,
    input  logic [REG_BIT_WIDTH-1:0]    alu_data,
    output logic                        alu_ready,
    input  logic                        ld_valid,
    input  logic [REG_ENCODE_WIDTH-1:0] ld_rd_addr,
    input  logic [REG_BIT_WIDTH-1:0]    ld_data,
    output logic                        ld_ready,
    output logic                        rd_wr_en,
    output logic [REG_ENCODE_WIDTH-1:0] rd_addr,
    output logic [REG_BIT_WIDTH-1:0]    rd_data,
    input  logic [REG_ENCODE_WIDTH-1:0] query_addr,
    output logic                        query_pending,
    output logic [$clog2(LQ_DEPTH):0]   lq_count
);

    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [SC_W-1:0]             starve_q, starve_d;
    logic [LQ_DEPTH-1:0]         vld_q, vld_d;
    logic [REG_ENCODE_WIDTH-1:0] lq_addr_q [LQ_DEPTH];
    logic [REG_BIT_WIDTH-1:0]    lq_data_q [LQ_DEPTH];

    logic                        wr_en_q, wr_en_d;
    logic [REG_ENCODE_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [REG_BIT_WIDTH-1:0]    wr_data_q, wr_data_d;

    logic q_empty, q_full, starve, alu_fire, lq_push, lq_pop, hit;

    assign q_empty   = (cnt_q == '0);
    assign q_full    = (cnt_q == CNT_W'(LQ_DEPTH));
    assign starve    = !q_empty && (starve_q == SC_W'(STARVE_LIMIT));
    assign alu_ready = !starve;
    assign ld_ready  = !q_full;
    assign alu_fire  = alu_valid && alu_ready;
    // Pop decisions use the registered count, so a fresh load waits at least one cycle.
    assign lq_pop    = !alu_fire && !q_empty;
    assign lq_push   = ld_valid && ld_ready && (ld_rd_addr != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        cnt_d    = cnt_q;
        if (lq_pop) begin
            rd_ptr_d        = rd_ptr_q + 1'b1;
            vld_d[rd_ptr_q] = 1'b0;
        end
        if (lq_push) begin
            wr_ptr_d        = wr_ptr_q + 1'b1;
            vld_d[wr_ptr_q] = 1'b1;
        end
        case ({lq_push, lq_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (lq_pop || q_empty) begin
            starve_d = '0;
        end else if (alu_fire && (starve_q != SC_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (alu_fire) begin
            wr_en_d   = (alu_rd_addr != '0);
            wr_addr_d = alu_rd_addr;
            wr_data_d = alu_data;
        end else if (lq_pop) begin
            wr_en_d   = 1'b1;
            wr_addr_d = lq_addr_q[rd_ptr_q];
            wr_data_d = lq_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        hit = wr_en_q && (wr_addr_q == query_addr);
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (vld_q[i] && (lq_addr_q[i] == query_addr)) begin
                hit = 1'b1;
            end
        end
        query_pending = (query_addr != '0) && hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            starve_q  <= '0;
            vld_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            vld_q     <= vld_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Entry storage is qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (lq_push) begin
            lq_addr_q[wr_ptr_q] <= ld_rd_addr;
            lq_data_q[wr_ptr_q] <= ld_data;
        end
    end

    assign rd_wr_en = wr_en_q;
    assign rd_addr  = wr_addr_q;
    assign rd_data  = wr_data_q;
    assign lq_count = cnt_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios with literal expectations plus a
// queue-based reference model compared against the DUT on every falling edge.
module tb_reg_writeback;

    localparam int W  = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int D  = 4;
    localparam int SL = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid;
    logic [AW-1:0] alu_rd_addr;
    logic [W-1:0]  alu_data;
    logic          alu_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_rd_addr;
    logic [W-1:0]  ld_data;
    logic          ld_ready;
    logic          rd_wr_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic [AW-1:0] query_addr;
    logic          query_pending;
    logic [2:0]    lq_count;

    reg_writeback #(
        .REG_BIT_WIDTH(W), .NUM_OF_REGS(NR), .REG_ENCODE_WIDTH(AW),
        .LQ_DEPTH(D), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd_addr(alu_rd_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd_addr(ld_rd_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .rd_wr_en(rd_wr_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .query_addr(query_addr), .query_pending(query_pending), .lq_count(lq_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } item_t;

    // Reference model: load queue as an SV queue, expected write port registers.
    item_t         m_q[$];
    int            m_starve = 0;
    logic          m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [W-1:0]  m_data = '0;

    always @(negedge clk) begin
        logic  e_ar, e_lr, e_qp, afire, pop, nonempty;
        item_t h;
        if (!rst) begin
            check("rst_wr_en", 32'(rd_wr_en), 32'd0);
            check("rst_addr", 32'(rd_addr), 32'd0);
            check("rst_data", rd_data, 32'd0);
            check("rst_count", 32'(lq_count), 32'd0);
            check("rst_alu_ready", 32'(alu_ready), 32'd1);
            check("rst_ld_ready", 32'(ld_ready), 32'd1);
            check("rst_qpend", 32'(query_pending), 32'd0);
            m_q.delete();
            m_starve = 0;
            m_wr = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            nonempty = (m_q.size() != 0);
            e_lr = (m_q.size() != D);
            e_ar = !(nonempty && m_starve == SL);
            e_qp = 1'b0;
            if (query_addr != '0) begin
                foreach (m_q[i]) if (m_q[i].a == query_addr) e_qp = 1'b1;
                if (m_wr && m_addr == query_addr) e_qp = 1'b1;
            end
            check("m_wr_en", 32'(rd_wr_en), 32'(m_wr));
            check("m_addr", 32'(rd_addr), 32'(m_addr));
            check("m_data", rd_data, m_data);
            check("m_count", 32'(lq_count), 32'(m_q.size()));
            check("m_alu_ready", 32'(alu_ready), 32'(e_ar));
            check("m_ld_ready", 32'(ld_ready), 32'(e_lr));
            check("m_qpend", 32'(query_pending), 32'(e_qp));

            afire = alu_valid && e_ar;
            pop = !afire && nonempty;
            if (afire) begin
                m_wr = (alu_rd_addr != '0);
                m_addr = alu_rd_addr;
                m_data = alu_data;
            end else if (pop) begin
                h = m_q.pop_front();
                m_wr = 1'b1;
                m_addr = h.a;
                m_data = h.d;
            end else begin
                m_wr = 1'b0;
            end
            if (pop || !nonempty) m_starve = 0;
            else if (afire && m_starve < SL) m_starve++;
            if (ld_valid && e_lr && ld_rd_addr != '0) m_q.push_back({ld_rd_addr, ld_data});
        end
    end

    // Source drivers: each holds its head item until it transfers.
    item_t aq[$];
    item_t lqd[$];

    task automatic present();
        alu_valid = (aq.size() != 0);
        alu_rd_addr = alu_valid ? aq[0].a : '0;
        alu_data = alu_valid ? aq[0].d : '0;
        ld_valid = (lqd.size() != 0);
        ld_rd_addr = ld_valid ? lqd[0].a : '0;
        ld_data = ld_valid ? lqd[0].d : '0;
    endtask

    task automatic cyc();
        logic ta, tl;
        present();
        #1;
        ta = alu_valid && alu_ready;
        tl = ld_valid && ld_ready;
        @(posedge clk);
        #1;
        if (ta) void'(aq.pop_front());
        if (tl) void'(lqd.pop_front());
        present();
        #1;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((aq.size() != 0 || lqd.size() != 0) && n < max) begin
            cyc();
            n++;
        end
        check("drain_timeout", 32'(aq.size() + lqd.size()), 32'd0);
        repeat (6) cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        query_addr = '0;
        present();
        repeat (2) @(posedge clk);
        #1;
        check("lit_rst_wr_en", 32'(rd_wr_en), 32'd0);
        check("lit_rst_alu_ready", 32'(alu_ready), 32'd1);
        check("lit_rst_ld_ready", 32'(ld_ready), 32'd1);
        rst = 1'b1;
        #1;

        // ALU only
        aq.push_back({5'd5, 32'hDEADBEEF});
        cyc();
        check("alu_wr_en", 32'(rd_wr_en), 32'd1);
        check("alu_addr", 32'(rd_addr), 32'd5);
        check("alu_data", rd_data, 32'hDEADBEEF);
        cyc();
        check("alu_wr_en_off", 32'(rd_wr_en), 32'd0);
        check("alu_data_hold", rd_data, 32'hDEADBEEF);

        // Load only into empty queue
        query_addr = 5'd7;
        lqd.push_back({5'd7, 32'h1234});
        cyc();
        check("ld_count1", 32'(lq_count), 32'd1);
        check("ld_qpend_n1", 32'(query_pending), 32'd1);
        check("ld_wr_en_n1", 32'(rd_wr_en), 32'd0);
        cyc();
        check("ld_wr_en_n2", 32'(rd_wr_en), 32'd1);
        check("ld_addr_n2", 32'(rd_addr), 32'd7);
        check("ld_data_n2", rd_data, 32'h1234);
        check("ld_qpend_n2", 32'(query_pending), 32'd1);
        cyc();
        check("ld_qpend_n3", 32'(query_pending), 32'd0);
        query_addr = '0;

        // Starvation
        lqd.push_back({5'd9, 32'h99});
        for (int k = 0; k < 6; k++) aq.push_back({5'(10 + k), 32'(32'h100 + k)});
        cyc();
        check("stv_count", 32'(lq_count), 32'd1);
        repeat (3) cyc();
        check("stv_alu_blocked", 32'(alu_ready), 32'd0);
        check("stv_last_alu", 32'(rd_addr), 32'd13);
        cyc();
        check("stv_ld_addr", 32'(rd_addr), 32'd9);
        check("stv_ld_data", rd_data, 32'h99);
        check("stv_alu_resume", 32'(alu_ready), 32'd1);
        cyc();
        check("stv_next_alu", 32'(rd_addr), 32'd14);
        drain(20);

        // Full queue, drain order
        for (int k = 0; k < 5; k++) lqd.push_back({5'(21 + k), 32'(32'h2000 + k)});
        for (int k = 0; k < 4; k++) aq.push_back({5'(1 + k), 32'(32'h300 + k)});
        repeat (4) cyc();
        check("full_count", 32'(lq_count), 32'd4);
        check("full_ld_ready", 32'(ld_ready), 32'd0);
        check("full_alu_ready", 32'(alu_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("full_order_addr", 32'(rd_addr), 32'(21 + k));
            check("full_order_data", rd_data, 32'(32'h2000 + k));
            if (k == 1) check("full_pushpop_count", 32'(lq_count), 32'd3);
        end
        check("full_drained", 32'(lq_count), 32'd0);
        drain(20);

        // x0 destinations
        aq.push_back({5'd0, 32'hAAAA});
        lqd.push_back({5'd0, 32'hBBBB});
        cyc();
        check("x0_wr_en", 32'(rd_wr_en), 32'd0);
        check("x0_count", 32'(lq_count), 32'd0);
        check("x0_qpend", 32'(query_pending), 32'd0);
        cyc();
        check("x0_wr_en2", 32'(rd_wr_en), 32'd0);
        check("x0_count2", 32'(lq_count), 32'd0);
        drain(20);

        // Asynchronous reset mid-operation
        query_addr = 5'd18;
        for (int k = 0; k < 6; k++) aq.push_back({5'(1 + k), 32'(32'h400 + k)});
        for (int k = 0; k < 3; k++) lqd.push_back({5'(17 + k), 32'(32'h500 + k)});
        repeat (3) cyc();
        check("pre_rst_count", 32'(lq_count), 32'd3);
        check("pre_rst_wr_en", 32'(rd_wr_en), 32'd1);
        check("pre_rst_qpend", 32'(query_pending), 32'd1);
        rst = 1'b0;
        aq.delete();
        lqd.delete();
        present();
        #1;
        check("arst_wr_en", 32'(rd_wr_en), 32'd0);
        check("arst_addr", 32'(rd_addr), 32'd0);
        check("arst_data", rd_data, 32'd0);
        check("arst_count", 32'(lq_count), 32'd0);
        check("arst_alu_ready", 32'(alu_ready), 32'd1);
        check("arst_ld_ready", 32'(ld_ready), 32'd1);
        check("arst_qpend", 32'(query_pending), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) cyc();
        check("post_rst_wr_en", 32'(rd_wr_en), 32'd0);
        check("post_rst_count", 32'(lq_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
